// File: rtl/dmem_bridge.sv
// -----------------------------------------------------------------------------
// dmem_bridge
//
// Purpose:
//   Sits downstream of the backend memory stage. Takes the opload/opstore index
//   channels, arbitrates them onto one request/response data-memory port, and
//   returns load data plus one-cycle operation_done pulses. Only one
//   transaction is in flight at a time.
//
// Optional feature macro:
//   DMEM_BRIDGE_TIMEOUT_EN - builds a response watchdog. If no response arrives
//   within TIMEOUT_CYCLES cycles of entering WAIT_RESP, the transaction is
//   completed anyway and the sticky mem_timeout_err flag is set. Without the
//   macro, WAIT_RESP waits indefinitely and mem_timeout_err is tied to 0.
//
// Handshake semantics (all channels):
//   A transfer happens on a rising clock edge where valid and ready are both
//   high. The one exception is the load channel when both request valids are
//   high in the same IDLE cycle: the store wins, and the load is treated as not
//   transferred even though its ready is high. Ready drops in the next cycle,
//   so the backend keeps the load pending.
//
// Ports:
//   clock, reset             rising-edge clock, async active-high reset
//   opload_index_*           load request channel (valid/ready/index)
//   opload_read_data         last completed load data
//   opload_operation_done    one-cycle pulse when a load completes
//   opstore_index_*          store request channel (valid/ready/index)
//   opstore_write_mask/data  store mask and data, captured on accept
//   opstore_operation_done   one-cycle pulse when a store completes
//   mem_req_*                memory request channel (valid/ready/write/addr/
//                            wdata/wmask); fields are 0 while valid is low
//   mem_resp_valid/rdata     one-cycle memory response
//   busy                     high in any state other than IDLE
//   mem_timeout_err          sticky watchdog error flag
// -----------------------------------------------------------------------------
module dmem_bridge #(
  parameter int IDX_W          = 19,
  parameter int DATA_W         = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              opload_index_valid,
  input  logic [IDX_W-1:0]  opload_index,
  output logic              opload_index_ready,
  output logic [DATA_W-1:0] opload_read_data,
  output logic              opload_operation_done,
  input  logic              opstore_index_valid,
  input  logic [IDX_W-1:0]  opstore_index,
  output logic              opstore_index_ready,
  input  logic [DATA_W-1:0] opstore_write_mask,
  input  logic [DATA_W-1:0] opstore_write_data,
  output logic              opstore_operation_done,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_write,
  output logic [IDX_W-1:0]  mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  output logic [DATA_W-1:0] mem_req_wmask,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_rdata,
  output logic              busy,
  output logic              mem_timeout_err
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("dmem_bridge: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_RESP = 2'd2,
    DONE      = 2'd3
  } state_t;

  // FSM state, kept as a named enum so checkers can bind to it directly.
  state_t state;
  state_t state_next;

  // Captured request.
  logic              req_write;
  logic [IDX_W-1:0]  req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [DATA_W-1:0] req_wmask;

  logic              accept_store;
  logic              accept_load;
  logic              timeout_hit;

  // Ready is held low while reset is asserted so every output reads 0 during
  // reset, and comes up the first cycle after release.
  assign opload_index_ready  = (state == IDLE) && !reset;
  assign opstore_index_ready = (state == IDLE) && !reset;

  // Store has priority when both requests are valid in the same cycle.
  assign accept_store = opstore_index_ready && opstore_index_valid;
  assign accept_load  = opload_index_ready && opload_index_valid && !opstore_index_valid;

  // ---------------------------------------------------------------------------
  // Response watchdog
  // ---------------------------------------------------------------------------
`ifdef DMEM_BRIDGE_TIMEOUT_EN
  localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_W   = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 32) ? 32 : CNT_RAW);

  logic [CNT_W-1:0] wd_cnt;
  logic             timeout_err;

  // The counter counts response-less WAIT_RESP cycles; the limit is reached
  // on the cycle whose increment would bring it to TIMEOUT_CYCLES. A response
  // in that same cycle takes priority and completes normally.
  assign timeout_hit = (state == WAIT_RESP) && !mem_resp_valid &&
                       (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wd_cnt <= '0;
    end else if (state == REQ && mem_req_ready) begin
      wd_cnt <= '0;
    end else if (state == WAIT_RESP && !mem_resp_valid && !timeout_hit) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timeout_err <= 1'b0;
    end else if (timeout_hit) begin
      timeout_err <= 1'b1;
    end
  end

  assign mem_timeout_err = timeout_err;
`else
  assign timeout_hit     = 1'b0;
  assign mem_timeout_err = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (accept_store || accept_load) state_next = REQ;
      REQ:       if (mem_req_ready) state_next = WAIT_RESP;
      WAIT_RESP: if (mem_resp_valid || timeout_hit) state_next = DONE;
      DONE:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request capture. Loads carry zero data/mask so the memory port never sees
  // stale store fields on a read.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      req_write <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      req_wmask <= '0;
    end else if (accept_store) begin
      req_write <= 1'b1;
      req_addr  <= opstore_index;
      req_wdata <= opstore_write_data;
      req_wmask <= opstore_write_mask;
    end else if (accept_load) begin
      req_write <= 1'b0;
      req_addr  <= opload_index;
      req_wdata <= '0;
      req_wmask <= '0;
    end
  end

  // Load data register: only a load's completion touches it, so it survives
  // any number of stores. A timed-out load returns 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      opload_read_data <= '0;
    end else if (state == WAIT_RESP && !req_write) begin
      if (mem_resp_valid) begin
        opload_read_data <= mem_resp_rdata;
      end else if (timeout_hit) begin
        opload_read_data <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_req_valid          = 1'b0;
    mem_req_write          = 1'b0;
    mem_req_addr           = '0;
    mem_req_wdata          = '0;
    mem_req_wmask          = '0;
    opload_operation_done  = 1'b0;
    opstore_operation_done = 1'b0;
    if (state == REQ) begin
      mem_req_valid = 1'b1;
      mem_req_write = req_write;
      mem_req_addr  = req_addr;
      mem_req_wdata = req_wdata;
      mem_req_wmask = req_wmask;
    end
    if (state == DONE) begin
      opload_operation_done  = !req_write;
      opstore_operation_done = req_write;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_dmem_bridge.sv
// -----------------------------------------------------------------------------
// tb_dmem_bridge
//
// Directed bench for dmem_bridge. Inputs change and outputs are sampled 1 ns
// after each rising edge. Expected load data is queued when a response is
// driven and popped on the matching load done pulse.
// -----------------------------------------------------------------------------
module tb_dmem_bridge;
  localparam int IDX_W  = 19;
  localparam int DATA_W = 64;
`ifdef DMEM_BRIDGE_TIMEOUT_EN
  localparam int TMO    = 4;
`else
  localparam int TMO    = 255;
`endif

  logic              clock = 1'b0;
  logic              reset;
  logic              opload_index_valid;
  logic [IDX_W-1:0]  opload_index;
  logic              opload_index_ready;
  logic [DATA_W-1:0] opload_read_data;
  logic              opload_operation_done;
  logic              opstore_index_valid;
  logic [IDX_W-1:0]  opstore_index;
  logic              opstore_index_ready;
  logic [DATA_W-1:0] opstore_write_mask;
  logic [DATA_W-1:0] opstore_write_data;
  logic              opstore_operation_done;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_write;
  logic [IDX_W-1:0]  mem_req_addr;
  logic [DATA_W-1:0] mem_req_wdata;
  logic [DATA_W-1:0] mem_req_wmask;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_resp_rdata;
  logic              busy;
  logic              mem_timeout_err;

  int errors = 0;
  int checks = 0;
  logic [DATA_W-1:0] exp_q[$];

  dmem_bridge #(
    .IDX_W(IDX_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock(clock), .reset(reset),
    .opload_index_valid(opload_index_valid), .opload_index(opload_index),
    .opload_index_ready(opload_index_ready), .opload_read_data(opload_read_data),
    .opload_operation_done(opload_operation_done),
    .opstore_index_valid(opstore_index_valid), .opstore_index(opstore_index),
    .opstore_index_ready(opstore_index_ready), .opstore_write_mask(opstore_write_mask),
    .opstore_write_data(opstore_write_data), .opstore_operation_done(opstore_operation_done),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .busy(busy), .mem_timeout_err(mem_timeout_err)
  );

  // Clock
  always #5 clock = ~clock;

  // Driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    opload_index_valid  = 1'b0;
    opload_index        = '0;
    opstore_index_valid = 1'b0;
    opstore_index       = '0;
    opstore_write_mask  = '0;
    opstore_write_data  = '0;
    mem_req_ready       = 1'b0;
    mem_resp_valid      = 1'b0;
    mem_resp_rdata      = '0;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ldone"}, 64'(opload_operation_done), 64'd0);
    check({tag, "_sdone"}, 64'(opstore_operation_done), 64'd0);
    check({tag, "_reqv"},  64'(mem_req_valid), 64'd0);
    check({tag, "_addr"},  64'(mem_req_addr), 64'd0);
    check({tag, "_wdata"}, mem_req_wdata, 64'd0);
    check({tag, "_wmask"}, mem_req_wmask, 64'd0);
    check({tag, "_write"}, 64'(mem_req_write), 64'd0);
  endtask

  task automatic check_load_done(input string tag);
    logic [DATA_W-1:0] exp_data;
    check({tag, "_ldone"}, 64'(opload_operation_done), 64'd1);
    check({tag, "_sdone"}, 64'(opstore_operation_done), 64'd0);
    check({tag, "_qlen"}, 64'(exp_q.size()), 64'd1);
    if (exp_q.size() != 0) begin
      exp_data = exp_q.pop_front();
      check({tag, "_rdata"}, opload_read_data, exp_data);
    end
  endtask

  initial begin
    // ---------------- reset ----------------
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    check("rst_lready", 64'(opload_index_ready), 64'd0);
    check("rst_sready", 64'(opstore_index_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rdata", opload_read_data, 64'd0);
    check("rst_err", 64'(mem_timeout_err), 64'd0);
    check_idle_outputs("rst");
    reset = 1'b0;
    tick();
    check("post_rst_lready", 64'(opload_index_ready), 64'd1);
    check("post_rst_sready", 64'(opstore_index_ready), 64'd1);
    check("post_rst_busy", 64'(busy), 64'd0);
    check_idle_outputs("post_rst");

    // ---------------- single load, immediate memory ----------------
    opload_index_valid = 1'b1;
    opload_index       = 19'h00010;
    mem_req_ready      = 1'b1;
    tick();                                   // cycle 1: REQ
    opload_index_valid = 1'b0;
    check("ld_reqv", 64'(mem_req_valid), 64'd1);
    check("ld_write", 64'(mem_req_write), 64'd0);
    check("ld_addr", 64'(mem_req_addr), 64'h10);
    check("ld_wmask", mem_req_wmask, 64'd0);
    check("ld_lready", 64'(opload_index_ready), 64'd0);
    check("ld_busy", 64'(busy), 64'd1);
    tick();                                   // cycle 2: WAIT_RESP
    check("ld_wait_reqv", 64'(mem_req_valid), 64'd0);
    check("ld_wait_done", 64'(opload_operation_done), 64'd0);
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 64'hDEADBEEF_CAFEF00D;
    exp_q.push_back(64'hDEADBEEF_CAFEF00D);
    tick();                                   // cycle 3: DONE
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
    check_load_done("ld");
    tick();                                   // cycle 4: IDLE, ready again
    check("ld_after_done", 64'(opload_operation_done), 64'd0);
    check("ld_after_ready", 64'(opload_index_ready), 64'd1);
    check("ld_after_rdata", opload_read_data, 64'hDEADBEEF_CAFEF00D);

    // Stray response in IDLE is ignored.
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 64'h5555_5555_5555_5555;
    tick();
    mem_resp_valid = 1'b0;
    check("stray_busy", 64'(busy), 64'd0);
    check("stray_rdata", opload_read_data, 64'hDEADBEEF_CAFEF00D);
    check_idle_outputs("stray");

    // ---------------- store with mem_req_ready low for 5 cycles ----------------
    mem_req_ready       = 1'b0;
    opstore_index_valid = 1'b1;
    opstore_index       = 19'h7FFFF;
    opstore_write_data  = 64'h1122334455667788;
    opstore_write_mask  = 64'h00000000FFFFFFFF;
    tick();
    opstore_index_valid = 1'b0;
    opstore_write_data  = '0;
    opstore_write_mask  = '0;
    for (int i = 0; i < 6; i++) begin
      check("st_reqv", 64'(mem_req_valid), 64'd1);
      check("st_write", 64'(mem_req_write), 64'd1);
      check("st_addr", 64'(mem_req_addr), 64'h7FFFF);
      check("st_wdata", mem_req_wdata, 64'h1122334455667788);
      check("st_wmask", mem_req_wmask, 64'h00000000FFFFFFFF);
      check("st_req_sdone", 64'(opstore_operation_done), 64'd0);
      if (i == 5) mem_req_ready = 1'b1;
      tick();
    end
    mem_req_ready  = 1'b0;
    check("st_wait_reqv", 64'(mem_req_valid), 64'd0);
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 64'hFFFF_0000_FFFF_0000;  // ignored for stores
    tick();
    mem_resp_valid = 1'b0;
    check("st_sdone", 64'(opstore_operation_done), 64'd1);
    check("st_ldone", 64'(opload_operation_done), 64'd0);
    check("st_keep_rdata", opload_read_data, 64'hDEADBEEF_CAFEF00D);
    tick();
    check("st_after_sdone", 64'(opstore_operation_done), 64'd0);
    check("st_after_ldone", 64'(opload_operation_done), 64'd0);
    check("st_after_busy", 64'(busy), 64'd0);

    // ---------------- load and store in the same cycle (zero-mask store) ----------------
    mem_req_ready       = 1'b1;
    opstore_index_valid = 1'b1;
    opstore_index       = 19'h00123;
    opstore_write_data  = 64'hA5A5_A5A5_0F0F_0F0F;
    opstore_write_mask  = 64'h0;
    opload_index_valid  = 1'b1;
    opload_index        = 19'h00456;
    check("both_sready", 64'(opstore_index_ready), 64'd1);
    tick();                                   // store REQ
    opstore_index_valid = 1'b0;
    check("both_st_write", 64'(mem_req_write), 64'd1);
    check("both_st_addr", 64'(mem_req_addr), 64'h123);
    check("both_st_wdata", mem_req_wdata, 64'hA5A5_A5A5_0F0F_0F0F);
    check("both_st_wmask", mem_req_wmask, 64'h0);
    check("both_lready_lo", 64'(opload_index_ready), 64'd0);
    tick();                                   // WAIT_RESP
    mem_resp_valid = 1'b1;
    tick();                                   // store DONE
    mem_resp_valid = 1'b0;
    check("both_sdone", 64'(opstore_operation_done), 64'd1);
    check("both_ldone_lo", 64'(opload_operation_done), 64'd0);
    check("both_done_lready", 64'(opload_index_ready), 64'd0);
    tick();                                   // IDLE: pending load accepted
    check("both_idle_lready", 64'(opload_index_ready), 64'd1);
    check("both_idle_done", 64'(opstore_operation_done | opload_operation_done), 64'd0);
    tick();                                   // load REQ
    opload_index_valid = 1'b0;
    check("both_ld_reqv", 64'(mem_req_valid), 64'd1);
    check("both_ld_write", 64'(mem_req_write), 64'd0);
    check("both_ld_addr", 64'(mem_req_addr), 64'h456);
    check("both_ld_wdata", mem_req_wdata, 64'd0);
    tick();                                   // WAIT_RESP
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 64'h0123456789ABCDEF;
    exp_q.push_back(64'h0123456789ABCDEF);
    tick();                                   // load DONE
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
    check_load_done("both_ld");
    tick();
    check("both_end_busy", 64'(busy), 64'd0);
    check("both_end_ldone", 64'(opload_operation_done), 64'd0);

    // ---------------- reset while in WAIT_RESP ----------------
    opload_index_valid = 1'b1;
    opload_index       = 19'h00777;
    tick();                                   // REQ
    opload_index_valid = 1'b0;
    tick();                                   // WAIT_RESP
    check("rw_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    check("rw_async_busy", 64'(busy), 64'd0);
    check("rw_async_rdata", opload_read_data, 64'd0);
    tick();
    reset = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    tick();
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
    check("rw_late_busy", 64'(busy), 64'd0);
    check("rw_late_rdata", opload_read_data, 64'd0);
    check_idle_outputs("rw_late");
    tick();
    check_idle_outputs("rw_late2");
    check("rw_late2_rdata", opload_read_data, 64'd0);

`ifdef DMEM_BRIDGE_TIMEOUT_EN
    // ---------------- watchdog: no response ----------------
    opload_index_valid = 1'b1;
    opload_index       = 19'h00011;
    tick();
    opload_index_valid = 1'b0;
    tick();                                   // WAIT_RESP, counter cleared
    for (int i = 0; i < TMO; i++) begin
      check("tmo_wait_busy", 64'(busy), 64'd1);
      check("tmo_wait_done", 64'(opload_operation_done), 64'd0);
      check("tmo_wait_err", 64'(mem_timeout_err), 64'd0);
      tick();
    end
    exp_q.push_back(64'd0);
    check_load_done("tmo");
    check("tmo_err", 64'(mem_timeout_err), 64'd1);
    tick();
    check("tmo_err_idle", 64'(mem_timeout_err), 64'd1);

    // Response in the limit cycle wins; flag stays sticky.
    opload_index_valid = 1'b1;
    opload_index       = 19'h00022;
    tick();
    opload_index_valid = 1'b0;
    tick();
    for (int i = 0; i < TMO - 1; i++) tick();
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 64'h0F1E2D3C4B5A6978;
    exp_q.push_back(64'h0F1E2D3C4B5A6978);
    tick();
    mem_resp_valid = 1'b0;
    check_load_done("tmo_edge");
    check("tmo_edge_err", 64'(mem_timeout_err), 64'd1);
    tick();
    check("tmo_sticky", 64'(mem_timeout_err), 64'd1);
`else
    // ---------------- no watchdog: waits forever ----------------
    opload_index_valid = 1'b1;
    opload_index       = 19'h00011;
    tick();
    opload_index_valid = 1'b0;
    for (int i = 0; i < 300; i++) tick();
    check("nowd_busy", 64'(busy), 64'd1);
    check("nowd_ldone", 64'(opload_operation_done), 64'd0);
    check("nowd_err", 64'(mem_timeout_err), 64'd0);
    check("nowd_ready", 64'(opload_index_ready), 64'd0);
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 64'h1357_9BDF_2468_ACE0;
    exp_q.push_back(64'h1357_9BDF_2468_ACE0);
    tick();
    mem_resp_valid = 1'b0;
    check_load_done("nowd");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
